// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier that retires one Booth digit per clock.
// A valid/ready handshake is used on both the operand side and the product side.
module booth_r4_seq_mult #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int CW = $clog2(W/2) + 1;
  localparam logic [CW-1:0]  LAST   = CW'(W/2 - 1);
  localparam logic [CW-1:0]  CNT1   = CW'(1);
  localparam logic [2*W-1:0] ONE_2W = (2*W)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic [2*W-1:0] acc_q, mcand_q, product_q;
  logic [W:0]     mreg_q;
  logic [CW-1:0]  cnt_q;
  logic           out_valid_q;

  logic [2*W-1:0] mcand2_d, pp_d, acc_d;

  // Partial product for the current Booth digit. Both the negations and the
  // doubling are done at full accumulator width.
  always_comb begin
    pp_d     = '0;
    mcand2_d = mcand_q << 1;
    unique case (mreg_q[2:0])
      3'b001, 3'b010: pp_d = mcand_q;
      3'b011:         pp_d = mcand2_d;
      3'b100:         pp_d = ~mcand2_d + ONE_2W;
      3'b101, 3'b110: pp_d = ~mcand_q + ONE_2W;
      default:        pp_d = '0;
    endcase
    acc_d = acc_q + pp_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mreg_q      <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand_q <= {{W{a[W-1]}}, a};
            mreg_q  <= {b, 1'b0};
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 2;
          mreg_q  <= {{2{mreg_q[W]}}, mreg_q[W:2]};
          cnt_q   <= cnt_q + CNT1;
          if (cnt_q == LAST) begin
            product_q   <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Product stays frozen here until the consumer takes it.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign busy      = (state_q != IDLE);

endmodule
